// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// Takes a word over a valid/ready handshake and sends it LSB first, with
// configurable data width, parity and stop-bit count. The bit divider restarts
// with every frame, so each bit lasts exactly CLK_DIV cycles.
module uart_tx_frame #(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_serial_o,
  output logic                 tx_busy_o,
  output logic                 tx_done_o
);

  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam int unsigned CW = $clog2(DATA_BITS);

  // Stop elaboration on parameter values the frame logic cannot support
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_frame: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [CW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   serial_q, serial_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   baud_end_c;
  logic                   data_last_c;
  logic                   stop_last_c;

  assign baud_end_c  = (baud_q == BW'(CLK_DIV - 1));
  assign data_last_c = (bit_q == CW'(DATA_BITS - 1));
  assign stop_last_c = (bit_q == CW'(STOP_BITS - 1));

  // Ready is a pure decode of the state so a word is taken only in IDLE
  assign tx_ready_o  = (state_q == S_IDLE);
  assign tx_serial_o = serial_q;
  assign tx_busy_o   = busy_q;
  assign tx_done_o   = done_q;

  // Next-state, counters and next registered output values
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = baud_end_c ? '0 : baud_q + BW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (tx_valid_i) begin
          state_d  = S_START;
          shift_d  = tx_data_i;
          par_d    = (PARITY == 2) ? (^tx_data_i) : ~(^tx_data_i);
          baud_d   = '0;
          bit_d    = '0;
          serial_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_START: begin
        if (baud_end_c) begin
          state_d  = S_DATA;
          bit_d    = '0;
          serial_d = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_end_c) begin
          if (data_last_c) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d  = S_PARITY;
              serial_d = par_q;
            end else begin
              state_d  = S_STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + CW'(1);
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (baud_end_c) begin
          state_d  = S_STOP;
          bit_d    = '0;
          serial_d = 1'b1;
        end
      end
      S_STOP: begin
        // Raise done one cycle early so the registered pulse lands in the last cycle
        done_d = stop_last_c && (baud_q == BW'(CLK_DIV - 2));
        if (baud_end_c) begin
          if (stop_last_c) begin
            state_d  = S_IDLE;
            bit_d    = '0;
            busy_d   = 1'b0;
            serial_d = 1'b1;
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule
